// File: rtl/timer_arbiter.sv
// -----------------------------------------------------------------------------
// timer_arbiter
//   Shares one countdown timer between NUM_REQ requesters. It picks an owner
//   round-robin and loads that owner's duration. It then pulses the timer start
//   and returns the timer expiry to the owner as a one-cycle done pulse.
//   Every output is registered, so there is no combinational path from an
//   input to an output.
//
// Parameters
//   NUM_REQ  number of requesters (2..8)
//   ID_W     width of owner_id, must be >= clog2(NUM_REQ)
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   req          level request per requester
//   req_dur      4-bit duration per requester, requester i at [4i+3:4i]
//   cancel       one-cycle abandon pulse; only the owner's bit is honoured
//   gnt          one-hot grant, high while the requester owns the timer
//   done         one-cycle pulse to the owner on timer expiry
//   preempted    one-cycle pulse to an owner displaced by requester 0
//   busy         high in every state except IDLE
//   owner_id     index of the current or last owner
//   tmr_start    start pulse to the timer
//   tmr_load     duration presented to the timer, stable around tmr_start
//   tmr_timeout  expiry pulse from the timer
//
// Build option
//   TMR_ARB_PREEMPT_EN  when defined, requester 0 is urgent and can displace
//                       another owner during RUN. When undefined, preempted
//                       stays 0 and requester 0 is plain round-robin.
//
// State  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no owner; a pending request is granted on the next edge
// START  | owner granted, timer start pulse is issued out of this state
// RUN    | countdown in progress; waiting for timeout, cancel or preempt
// RELEASE| grant dropped on the next edge; gives a one-cycle gap between owners
// -----------------------------------------------------------------------------
module timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] req_dur,
  input  logic [NUM_REQ-1:0]   cancel,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   preempted,
  output logic                 busy,
  output logic [ID_W-1:0]      owner_id,
  output logic                 tmr_start,
  output logic [3:0]           tmr_load,
  input  logic                 tmr_timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_RUN     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t state, state_d;

  logic [ID_W-1:0]    rr_ptr, rr_ptr_d;
  logic               urgent, urgent_d;
  logic [NUM_REQ-1:0] gnt_d, done_d, preempted_d;
  logic               busy_d, tmr_start_d;
  logic [ID_W-1:0]    owner_id_d;
  logic [3:0]         tmr_load_d;

  logic               sel_found;
  logic [ID_W-1:0]    sel_idx;
  int                 scan_idx;
  logic               owner_cancel;
  logic               preempt_hit;

  // Round-robin search starting just after the last owner, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!sel_found && req[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(scan_idx);
      end
    end
`ifdef TMR_ARB_PREEMPT_EN
    // After a preemption requester 0 jumps the queue once.
    if (urgent && req[0]) begin
      sel_found = 1'b1;
      sel_idx   = '0;
    end
`endif
  end

  assign owner_cancel = cancel[owner_id];

`ifdef TMR_ARB_PREEMPT_EN
  assign preempt_hit = req[0] && (owner_id != '0);
`else
  assign preempt_hit = 1'b0;
`endif

  // State register plus output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      urgent    <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      preempted <= '0;
      busy      <= 1'b0;
      owner_id  <= '0;
      tmr_start <= 1'b0;
      tmr_load  <= '0;
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_ptr_d;
      urgent    <= urgent_d;
      gnt       <= gnt_d;
      done      <= done_d;
      preempted <= preempted_d;
      busy      <= busy_d;
      owner_id  <= owner_id_d;
      tmr_start <= tmr_start_d;
      tmr_load  <= tmr_load_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (sel_found) state_d = S_START;
      S_START:   state_d = S_RUN;
      S_RUN:     if (owner_cancel || tmr_timeout || preempt_hit) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    gnt_d       = gnt;
    done_d      = '0;
    preempted_d = '0;
    busy_d      = busy;
    owner_id_d  = owner_id;
    tmr_start_d = 1'b0;
    tmr_load_d  = tmr_load;
    rr_ptr_d    = rr_ptr;
    urgent_d    = urgent;
    case (state)
      S_IDLE: begin
        if (sel_found) begin
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          owner_id_d     = sel_idx;
          tmr_load_d     = req_dur[4*int'(sel_idx) +: 4];
          busy_d         = 1'b1;
          urgent_d       = 1'b0;
        end
      end
      S_START: begin
        tmr_start_d = 1'b1;
      end
      S_RUN: begin
        // Owner cancel beats timeout, and timeout beats preemption.
        if (owner_cancel) begin
          done_d = '0;
        end else if (tmr_timeout) begin
          done_d[owner_id] = 1'b1;
        end else if (preempt_hit) begin
          preempted_d[owner_id] = 1'b1;
          urgent_d              = 1'b1;
        end
      end
      S_RELEASE: begin
        gnt_d    = '0;
        busy_d   = 1'b0;
        rr_ptr_d = owner_id;
      end
      default: begin
        gnt_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares the single countdown timer between NUM_REQ requesters: game-round timer, input-error lockout, result-display hold, and similar.
- Selects one owner by round-robin and loads that owner's duration into the timer.
- Issues the timer start pulse and routes the timer's timeout back to the owner as a done pulse.
- Sits between the main FSM sub-blocks and the timer instance. Its tmr_load output drives the timer's switch/config input bits [3:0].

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of owner_id; must be >= clog2(NUM_REQ).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  NUM_REQ  level request per requester; held until done, cancel or preempt.
- req_dur  in  4*NUM_REQ  seconds per requester; requester i uses bits [4i+3:4i].
- cancel  in  NUM_REQ  one-cycle pulse; owner abandons its countdown.
- gnt  out  NUM_REQ  one-hot; high while requester owns the timer.
- done  out  NUM_REQ  one-cycle pulse to the owner on timer expiry.
- preempted  out  NUM_REQ  one-cycle pulse to an owner displaced by preemption (always 0 without the feature).
- busy  out  1  high in any state other than IDLE.
- owner_id  out  ID_W  index of the current or last owner.
- tmr_start  out  1  start pulse to the timer.
- tmr_load  out  4  duration presented to the timer; valid during tmr_start.
- tmr_timeout  in  1  timer expiry pulse.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer rr_ptr = NUM_REQ-1, so requester 0 has first priority after reset.
- Registered outputs only; no combinational path from any input to any output.

State machine: IDLE, START, RUN, RELEASE.
- IDLE:
  - If req != 0, pick the first set bit searching from index rr_ptr+1 upward, modulo NUM_REQ.
  - Next cycle: gnt[sel]=1, owner_id=sel, tmr_load=req_dur[sel], busy=1, state=START.
  - No request: stay in IDLE, outputs unchanged (owner_id retains its last value).
- START:
  - tmr_start=1 for exactly this cycle; tmr_load is stable.
  - Next state RUN unconditionally.
- RUN:
  - Wait for tmr_timeout.
  - On tmr_timeout: done[owner]=1 for one cycle, state=RELEASE.
  - On cancel[owner]: no done, state=RELEASE.
  - Cancel and timeout in the same cycle: cancel wins, no done.
  - cancel bits of non-owners are ignored in every state.
  - req[owner] dropping without cancel is ignored; the countdown continues and done is still pulsed.
- RELEASE:
  - gnt=0, rr_ptr=owner_id, busy=0, state=IDLE.
  - Gives a minimum one-cycle gap between owners.
- tmr_timeout outside RUN is ignored. This covers stale expiries after a cancel: the timer has no stop input and keeps counting until the next tmr_start reloads it.
- Duration values are forwarded raw. The timer substitutes 10 s for values < 5; the arbiter does not check them.
- Timing:
  - Grant latency from req rising in IDLE: 1 cycle to gnt, 2 cycles to tmr_start.
  - done asserts the cycle after tmr_timeout.
- Fairness:
  - A requester holding req high after its done is searched last.
  - Any other pending requester is granted first.
- Asynchronous reset mid-RUN clears gnt, done and tmr_start immediately. The timer's own reset is separate.

Optional Feature:
- Macro: TMR_ARB_PREEMPT_EN.
- Defined:
  - Requester 0 is urgent. If req[0]=1 while in RUN and owner_id != 0, pulse preempted[owner]=1 and go to RELEASE (no done).
  - In the cycle after RELEASE, IDLE grants requester 0 regardless of rr_ptr.
  - Preempt and tmr_timeout in the same RUN cycle: timeout wins, done is pulsed, no preempted.
  - Cancel from the owner in that cycle still beats both.
- Undefined:
  - preempted is tied to 0.
  - Requester 0 uses ordinary round-robin.

Test Plan:
- Single request: req=0001, req_dur[3:0]=7 -> gnt=0001 at T+1; tmr_start=1 with tmr_load=7 at T+2; timeout injected at T+50 -> done=0001 at T+51; gnt=0 at T+52; busy low.
- Round-robin: req=0110 held, owner 1 completes -> next grant is 0100 (req 2), then 0010, alternating; never 1 twice while 2 is pending.
- Cancel: owner 2 in RUN, cancel=0100 -> no done, gnt cleared 2 cycles later. A later tmr_timeout while IDLE produces no done and no state change.
- Cancel and timeout in the same cycle for owner 3 -> done stays 0, state returns to IDLE.
- Reset mid-RUN: rst_n low for 3 cycles during owner 1's countdown -> all outputs 0 immediately. After release, req=0010 grants 1 with a fresh tmr_start.
- TMR_ARB_PREEMPT_EN: owner 2 in RUN, req[0] rises -> preempted=0100 next cycle, then gnt=0001 and tmr_start with req_dur[3:0]. Without the macro, the same stimulus leaves owner 2 running until its timeout.
